// File: rtl/sdram_read.sv
// Read-side SDRAM command sequencer: ACTIVE -> READ (page burst) -> BURST STOP -> PRECHARGE.
// Commands and rd_end are registered; rd_ack/rd_sdram_data are decoded from registered state.
module sdram_read #(
  parameter logic [9:0] TRCD_CLK = 10'd2,
  parameter logic [9:0] TRP_CLK  = 10'd2,
  parameter logic [9:0] CAS_LAT  = 10'd3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [20:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [31:0] rd_data,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  read_cmd,
  output logic [1:0]  read_ba,
  output logic [10:0] read_addr,
  output logic [31:0] rd_sdram_data
);

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BSTOP  = 4'b0110;
  localparam logic [3:0] CMD_PCHG   = 4'b0010;

  typedef enum logic [3:0] {
    RD_IDLE   = 4'd0,
    RD_ACTIVE = 4'd1,
    RD_TRCD   = 4'd2,
    RD_READ   = 4'd3,
    RD_DATA   = 4'd4,
    RD_PRE    = 4'd5,
    RD_TRP    = 4'd6,
    RD_END    = 4'd7
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [20:0] lat_addr_q, lat_addr_d;
  logic [9:0]  len_q, len_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [10:0] addr_q, addr_d;
  logic        end_q, end_d;
  logic [31:0] data_q;
  logic [9:0]  len_in;

  always_comb begin
    if (rd_burst_len == 10'd0) begin
      len_in = 10'd1;
    end else if (rd_burst_len > 10'd256) begin
      len_in = 10'd256;
    end else begin
      len_in = rd_burst_len;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 10'd1;
    lat_addr_d = lat_addr_q;
    len_d      = len_q;
    cmd_d      = CMD_NOP;
    ba_d       = 2'b11;
    addr_d     = 11'h7ff;
    end_d      = 1'b0;
    case (state_q)
      RD_IDLE: begin
        cnt_d = 10'd0;
        if (rd_en && init_end) begin
          state_d    = RD_ACTIVE;
          lat_addr_d = rd_addr;
          len_d      = len_in;
        end
      end
      RD_ACTIVE: begin
        state_d = RD_TRCD;
        cmd_d   = CMD_ACTIVE;
        ba_d    = lat_addr_q[20:19];
        addr_d  = lat_addr_q[18:8];
      end
      RD_TRCD: begin
        if (cnt_q == TRCD_CLK) begin
          state_d = RD_READ;
          cnt_d   = 10'd0;
        end
      end
      RD_READ: begin
        state_d = RD_DATA;
        cnt_d   = 10'd0;
        cmd_d   = CMD_READ;
        ba_d    = lat_addr_q[20:19];
        addr_d  = {3'b000, lat_addr_q[7:0]};
      end
      RD_DATA: begin
        // Burst stop lands len cycles after READ; bank/address lines are left as they were.
        if (cnt_q == len_q - 10'd1) begin
          cmd_d  = CMD_BSTOP;
          ba_d   = ba_q;
          addr_d = addr_q;
        end
        if (cnt_q == CAS_LAT + len_q) begin
          state_d = RD_PRE;
          cnt_d   = 10'd0;
        end
      end
      RD_PRE: begin
        state_d = RD_TRP;
        cmd_d   = CMD_PCHG;
        ba_d    = lat_addr_q[20:19];
        addr_d  = 11'h400;
      end
      RD_TRP: begin
        if (cnt_q == TRP_CLK) begin
          state_d = RD_END;
          cnt_d   = 10'd0;
        end
      end
      RD_END: begin
        state_d = RD_IDLE;
        cnt_d   = 10'd0;
        end_d   = 1'b1;
      end
      default: begin
        state_d = RD_IDLE;
        cnt_d   = 10'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= RD_IDLE;
      cnt_q      <= 10'd0;
      lat_addr_q <= 21'd0;
      len_q      <= 10'd1;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'b11;
      addr_q     <= 11'h7ff;
      end_q      <= 1'b0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      data_q     <= rd_data;
    end
  end

  // The first CAS_LAT+1 DATA cycles cover CAS latency plus the input register.
  assign rd_ack        = (state_q == RD_DATA) && (cnt_q >= CAS_LAT + 10'd1);
  assign rd_sdram_data = rd_ack ? data_q : 32'd0;
  assign rd_end        = end_q;
  assign read_cmd      = cmd_q;
  assign read_ba       = ba_q;
  assign read_addr     = addr_q;

endmodule
